mac_sequencer: RTL and testbench

Controller that sequences one `mac` instance through a dot product of N operand pairs. It issues read addresses to the A and B operand buffers and compensates their read latency. It drives the MAC's `input_valid` and `accumulate_internal` so that accumulation restarts on the first pair, then presents the finished result with a valid/ready handshake. It sits between the layer-level scheduler (start/len/base) and the MAC datapath plus its operand SRAMs.

---
 rtl/mac_sequencer.sv | 131 +++++++++++++
 tb/tb_mac_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one MAC through an N-pair dot product, compensating operand
// buffer read latency and presenting the result with a valid/ready handshake.
// Optional feature: define MAC_SEQ_PERF_CNT_EN to enable the busy_cycles counter.
module mac_sequencer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int CNT_WIDTH   = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  start,
    output logic                  ready,
    input  logic [CNT_WIDTH-1:0]  len_in,
    input  logic [ADDR_WIDTH-1:0] base_a_in,
    input  logic [ADDR_WIDTH-1:0] base_b_in,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  mac_input_valid,
    output logic                  mac_accumulate_internal,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           busy_cycles
);
    localparam int DW = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUTPUT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    len_q, len_d;
    logic [CNT_WIDTH-1:0]    idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   base_a_q, base_a_d;
    logic [ADDR_WIDTH-1:0]   base_b_q, base_b_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [MEM_LATENCY-1:0]  vld_q, vld_d;
    logic [MEM_LATENCY-1:0]  fst_q, fst_d;
    logic                    first;

    assign ready                   = state_q == IDLE;
    assign rd_en                   = state_q == RUN;
    assign out_valid               = state_q == OUTPUT;
    assign first                   = rd_en && idx_q == '0;
    assign rd_addr_a               = base_a_q + ADDR_WIDTH'(idx_q);
    assign rd_addr_b               = base_b_q + ADDR_WIDTH'(idx_q);
    assign mac_input_valid         = vld_q[MEM_LATENCY-1];
    assign mac_accumulate_internal = vld_q[MEM_LATENCY-1] & ~fst_q[MEM_LATENCY-1];

    // Next-state logic: job acceptance, index stepping, drain timing and handshake.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        drain_d  = drain_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d  = RUN;
                    len_d    = len_in;
                    base_a_d = base_a_in;
                    base_b_d = base_b_in;
                    idx_d    = '0;
                end
                RUN: begin
                    idx_d = idx_q + CNT_WIDTH'(1);
                    if (idx_q == len_q) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
                DRAIN: begin
                    drain_d = drain_q + DW'(1);
                    if (drain_q == DW'(MEM_LATENCY - 1)) state_d = OUTPUT;
                end
                OUTPUT: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Issue pipeline tracking read latency; abort flushes any in-flight reads.
    always_comb begin
        vld_d = abort ? '0 : (vld_q << 1) | MEM_LATENCY'(rd_en);
        fst_d = abort ? '0 : (fst_q << 1) | MEM_LATENCY'(first);
    end

    // Control and pipeline registers.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q  <= IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            drain_q  <= '0;
            vld_q    <= '0;
            fst_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            drain_q  <= drain_d;
            vld_q    <= vld_d;
            fst_q    <= fst_d;
        end
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    logic [31:0] busy_q;

    // Saturating count of non-idle cycles, cleared only by reset.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            busy_q <= '0;
        end else if (state_q != IDLE && busy_q != '1) begin
            busy_q <= busy_q + 32'd1;
        end
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed checks of mac_sequencer with L=1 and L=2 instances and a MAC model.
module tb_mac_sequencer;
    logic        clk, rst_n, start1, start2, abort, out_ready;
    logic [9:0]  len, base_a, base_b;
    logic        ready1, rd_en1, v1, ai1, ov1;
    logic        ready2, rd_en2, v2, ai2, ov2;
    logic [9:0]  ra1, rb1, ra2, rb2;
    logic [31:0] busy1, busy2;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] qa, qb, acc_m;
    int          n_tests, n_fail;

`ifdef MAC_SEQ_PERF_CNT_EN
    localparam logic [31:0] BUSY_EXP = 32'd6;
`else
    localparam logic [31:0] BUSY_EXP = 32'd0;
`endif

    typedef struct {
        logic       start;
        logic       out_ready;
        logic       rd_en;
        logic [9:0] addr_a;
        logic [9:0] addr_b;
        logic       valid;
        logic       acc;
        logic       out_valid;
        logic       ready;
    } vec_t;

    vec_t tbl [8];

    mac_sequencer #(.ADDR_WIDTH(10), .CNT_WIDTH(10), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .arst_n_in(rst_n), .start(start1), .ready(ready1), .len_in(len),
        .base_a_in(base_a), .base_b_in(base_b), .abort(abort), .rd_en(rd_en1),
        .rd_addr_a(ra1), .rd_addr_b(rb1), .mac_input_valid(v1),
        .mac_accumulate_internal(ai1), .out_valid(ov1), .out_ready(out_ready),
        .busy_cycles(busy1)
    );

    mac_sequencer #(.ADDR_WIDTH(10), .CNT_WIDTH(10), .MEM_LATENCY(2)) u_dut2 (
        .clk(clk), .arst_n_in(rst_n), .start(start2), .ready(ready2), .len_in(len),
        .base_a_in(base_a), .base_b_in(base_b), .abort(abort), .rd_en(rd_en2),
        .rd_addr_a(ra2), .rd_addr_b(rb2), .mac_input_valid(v2),
        .mac_accumulate_internal(ai2), .out_valid(ov2), .out_ready(out_ready),
        .busy_cycles(busy2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // One-cycle-latency operand buffers feeding a MAC, driven by the L=1 instance.
    always @(posedge clk) begin
        if (rd_en1) begin
            qa <= mem_a[ra1];
            qb <= mem_b[rb1];
        end
        if (v1) acc_m <= ai1 ? acc_m + qa * qb : qa * qb;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] wrap_a [4];
        logic [9:0] wrap_b [4];
        n_tests = 0;
        n_fail = 0;
        rst_n = 0; start1 = 0; start2 = 0; abort = 0; out_ready = 1;
        len = '0; base_a = '0; base_b = '0;
        acc_m = 0; qa = 0; qb = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 0;
            mem_b[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[10'h010 + i] = 32'(i + 1);
            mem_b[10'h200 + i] = 32'(i + 5);
        end
        wrap_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        wrap_b = '{10'h001, 10'h002, 10'h003, 10'h004};
        //           start orr rd  addr_a   addr_b   vld acc ov  rdy
        tbl[0] = '{1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 10'h010, 10'h200, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 10'h011, 10'h201, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 10'h012, 10'h202, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 10'h013, 10'h203, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1};

        repeat (2) tick();
        chk("rst_ready", ready1, 1);
        chk("rst_rd_en", rd_en1, 0);
        chk("rst_addr_a", ra1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_acc", ai1, 0);
        chk("rst_out_valid", ov1, 0);
        chk("rst_busy", busy1, 0);
        rst_n = 1;
        tick();

        len = 10'd3; base_a = 10'h010; base_b = 10'h200;
        for (int c = 0; c < 8; c++) begin
            start1 = tbl[c].start;
            out_ready = tbl[c].out_ready;
            @(negedge clk);
            chk($sformatf("basic_rd_en[%0d]", c), rd_en1, tbl[c].rd_en);
            if (tbl[c].rd_en) begin
                chk($sformatf("basic_addr_a[%0d]", c), ra1, tbl[c].addr_a);
                chk($sformatf("basic_addr_b[%0d]", c), rb1, tbl[c].addr_b);
            end
            chk($sformatf("basic_valid[%0d]", c), v1, tbl[c].valid);
            chk($sformatf("basic_acc[%0d]", c), ai1, tbl[c].acc);
            chk($sformatf("basic_out_valid[%0d]", c), ov1, tbl[c].out_valid);
            chk($sformatf("basic_ready[%0d]", c), ready1, tbl[c].ready);
            if (c == 6) chk("basic_result", acc_m, 70);
            if (c == 7) chk("basic_busy", busy1, BUSY_EXP);
            tick();
        end
        start1 = 0;

        len = 10'd0;
        for (int c = 0; c < 6; c++) begin
            start2 = (c == 0);
            @(negedge clk);
            chk($sformatf("single_rd_en[%0d]", c), rd_en2, c == 1);
            chk($sformatf("single_valid[%0d]", c), v2, c == 3);
            chk($sformatf("single_acc[%0d]", c), ai2, 0);
            chk($sformatf("single_out_valid[%0d]", c), ov2, c == 4);
            if (c == 5) chk("single_ready", ready2, 1);
            tick();
        end
        start2 = 0;

        len = 10'd3; base_a = 10'h3FE; base_b = 10'h001;
        for (int c = 0; c < 8; c++) begin
            start1 = (c == 0);
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("wrap_addr_a[%0d]", c), ra1, wrap_a[c-1]);
                chk($sformatf("wrap_addr_b[%0d]", c), rb1, wrap_b[c-1]);
            end
            if (c == 7) chk("wrap_ready", ready1, 1);
            tick();
        end
        start1 = 0;

        len = 10'd1; base_a = 10'h010; base_b = 10'h200;
        for (int c = 0; c < 16; c++) begin
            if (c == 10) begin
                base_a = 10'h012;
                base_b = 10'h202;
            end
            start1 = (c == 0) || (c == 5) || (c == 7) || (c == 10);
            out_ready = (c >= 9);
            @(negedge clk);
            if (c >= 4 && c <= 8) begin
                chk($sformatf("bp_out_valid[%0d]", c), ov1, 1);
                chk($sformatf("bp_ready[%0d]", c), ready1, 0);
                chk($sformatf("bp_rd_en[%0d]", c), rd_en1, 0);
            end
            if (c == 4) chk("bp_result1", acc_m, 17);
            if (c == 9) chk("bp_hold_at_handshake", ov1, 1);
            if (c == 10) chk("bp_ready_after", ready1, 1);
            if (c == 14) begin
                chk("bp_out_valid2", ov1, 1);
                chk("bp_result2", acc_m, 53);
            end
            if (c == 15) chk("bp_ready2", ready1, 1);
            tick();
        end
        start1 = 0; out_ready = 1;

        len = 10'd7; base_a = 10'h000; base_b = 10'h000;
        for (int c = 0; c < 14; c++) begin
            start1 = (c == 0) || (c == 6);
            abort = (c == 2) || (c == 6);
            @(negedge clk);
            if (c == 1) chk("abort_rd_en_pre", rd_en1, 1);
            if (c >= 3) begin
                chk($sformatf("abort_ready[%0d]", c), ready1, 1);
                chk($sformatf("abort_rd_en[%0d]", c), rd_en1, 0);
                chk($sformatf("abort_valid[%0d]", c), v1, 0);
                chk($sformatf("abort_out_valid[%0d]", c), ov1, 0);
            end
            tick();
        end
        start1 = 0; abort = 0;

        start1 = 1;
        tick();
        start1 = 0;
        tick();
        chk("arst_pre_rd_en", rd_en1, 1);
        chk("arst_pre_valid", v1, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_ready", ready1, 1);
        chk("arst_rd_en", rd_en1, 0);
        chk("arst_addr_a", ra1, 0);
        chk("arst_valid", v1, 0);
        chk("arst_out_valid", ov1, 0);
        chk("arst_busy", busy1, 0);
        tick();
        rst_n = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
